// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM hazard inputs and the
// stall/flush controls returned to the pipeline.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              ex_mem_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mem_wb_flush;
    logic              mem_timeout;
    logic [15:0]       stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_flush, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_flush, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes with a timeout into a sticky error state.
module hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    localparam logic [REG_AW-1:0] RegZero     = '0;
    localparam logic [7:0]        TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e      state_q;
    state_e      cur_state;
    logic [7:0]  wait_cnt_q;
    logic        timeout_q;
    logic [15:0] stall_cnt_q;

    logic lu;
    logic ms;
    logic freeze;
    logic pc_en;

    assign lu = bus.ex_mem_read && (bus.ex_rd != RegZero) &&
                ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign ms = bus.mem_req && !bus.mem_ready;

    // Reset shows the RUN decode of the live inputs.
    assign cur_state = rst ? StRun : state_q;

    // MEM_WAIT release cycle behaves as RUN with the ms term forced low.
    assign freeze = (cur_state == StErr) ||
                    ((cur_state == StRun) && ms) ||
                    ((cur_state == StMemWait) && !bus.mem_ready);

    always_comb begin
        pc_en            = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.mem_wb_flush = 1'b0;
        if (freeze) begin
            pc_en            = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_en           = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
        bus.pc_en       = pc_en;
        bus.mem_timeout = timeout_q;
        bus.stall_cnt   = stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            unique case (state_q)
                StRun: begin
                    if (ms) begin
                        wait_cnt_q <= 8'd0;
                        state_q    <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (bus.mem_ready) begin
                        state_q <= StRun;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        // The stall cycle in RUN counts toward the MEM_TIMEOUT budget.
                        if ((wait_cnt_q + 8'd1) == TimeoutLast) begin
                            state_q   <= StErr;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                StErr: begin
                    timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes hand-computed expectations,
// a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

    localparam logic [3:0] E1 = 4'b1111;
    localparam logic [3:0] E0 = 4'b0000;
    localparam logic [3:0] EL = 4'b0011;
    localparam logic [2:0] FN = 3'b000;
    localparam logic [2:0] FB = 3'b110;
    localparam logic [2:0] FL = 3'b010;
    localparam logic [2:0] FM = 3'b001;

    typedef struct packed {
        logic [3:0]  en;
        logic [2:0]  fl;
        logic        tmo;
        logic [15:0] sc;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    hazard_ctrl_if #(.REG_AW(5)) hif ();

    hazard_ctrl #(
        .REG_AW      (5),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic lr, input logic br, input logic mq, input logic my,
                        input logic [3:0] en, input logic [2:0] fl, input logic tmo,
                        input logic [15:0] sc, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        rst                 = r;
        hif.id_rs1          = rs1;
        hif.id_use_rs1      = u1;
        hif.id_rs2          = rs2;
        hif.id_use_rs2      = u2;
        hif.ex_rd           = rd;
        hif.ex_mem_read     = lr;
        hif.ex_branch_taken = br;
        hif.mem_req         = mq;
        hif.mem_ready       = my;
        it.e    = '{en: en, fl: fl, tmo: tmo, sc: sc};
        it.name = nm;
        q.push_back(it);
    endtask

    initial begin : monitor
        item_t it;
        exp_t  got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                it  = q.pop_front();
                got = '{en:  {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en},
                        fl:  {hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_flush},
                        tmo: hif.mem_timeout,
                        sc:  hif.stall_cnt};
                checks++;
                if (got !== it.e) begin
                    errors++;
                    $display("FAIL %s: got en=%b fl=%b tmo=%b cnt=%0d, want en=%b fl=%b tmo=%b cnt=%0d",
                             it.name, got.en, got.fl, got.tmo, got.sc,
                             it.e.en, it.e.fl, it.e.tmo, it.e.sc);
                end
            end
        end
    end

    initial begin : driver
        hif.id_rs1 = '0; hif.id_use_rs1 = 1'b0; hif.id_rs2 = '0; hif.id_use_rs2 = 1'b0;
        hif.ex_rd = '0; hif.ex_mem_read = 1'b0; hif.ex_branch_taken = 1'b0;
        hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rst rs1 u1 rs2 u2 rd lr br mq my   en  fl  tmo cnt
        step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0,  EL, FL, 0, 0, "rst_run_decode");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E1, FN, 0, 0, "reset_state");
        step(0, 5, 1, 0, 0, 5, 1, 0, 0, 0,  EL, FL, 0, 0, "lu_rs1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E1, FN, 0, 1, "lu_one_bubble");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  E1, FN, 0, 1, "lu_x0");
        step(0, 3, 1, 7, 1, 7, 1, 0, 0, 0,  EL, FL, 0, 1, "lu_rs2");
        step(0, 3, 1, 7, 0, 7, 1, 0, 0, 0,  E1, FN, 0, 2, "rs2_unused");
        step(0, 7, 1, 7, 1, 7, 0, 0, 0, 0,  E1, FN, 0, 2, "not_load");
        step(0, 5, 1, 0, 0, 5, 1, 1, 0, 0,  E1, FB, 0, 2, "branch_over_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  E1, FN, 0, 2, "mem_ready_hit");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 2, "ms_enter");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 3, "mw_1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 4, "mw_2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  E1, FN, 0, 5, "mw_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E1, FN, 0, 5, "back_to_run");
        step(0, 5, 1, 0, 0, 5, 1, 1, 1, 0,  E0, FM, 0, 5, "ms_priority");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  E1, FB, 0, 6, "release_branch");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 6, "ms_again");
        step(0, 5, 1, 0, 0, 5, 1, 0, 1, 1,  EL, FL, 0, 7, "release_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E1, FN, 0, 8, "run_after_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 8, "ms_pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 9, "mw_pre_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  E0, FM, 0, 10, "rst_mid_wait");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  E1, FN, 0, 0, "no_spurious");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  E1, FN, 0, 0, "run_hit_after_rst");

        // A stale wait count after the mid-wait reset would shorten this run.
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E0, FM, 0, 16'(i), "timeout_wait");
        end
        for (int i = 16; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E0, FM, 1, 16'(i), "err_frozen");
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  E1, FN, 1, 20, "rst_in_err");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  E1, FN, 0, 0, "after_err_rst");

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
